// File: rtl/bus_pkg.sv
// Shared encodings for the CPU memory-access back end: FSM states, window
// selects and lane-shift helpers used by cpu_bus_ctrl and its lane aligner.
package bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_RAM  = 2'd1;
  localparam logic [1:0] WIN_IO   = 2'd2;

  localparam int unsigned BUS_LANES  = 4;
  localparam int unsigned LANE_WIDTH = 8;

  // Bit distance for a byte-lane offset (off * 8).
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {off, 3'b000};
  endfunction

endpackage

// File: rtl/cpu_bus_lane_aligner.sv
// Combinational byte-lane steering between the CPU's low-aligned lanes and
// the bus lanes selected by the low address bits.
module cpu_bus_lane_aligner
  import bus_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [3:0]  i_mask,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [4:0] w_shift;

  always_comb begin
    w_shift = lane_shift(i_off);
    // Lanes shifted past bit 3 are dropped, matching (mask << off)[3:0].
    o_be    = i_mask << i_off;
    o_wdata = i_wdata << w_shift;
    o_rdata = i_rdata >> w_shift;
  end

endmodule

// File: rtl/cpu_bus_ctrl.sv
// CPU memory-access back end: decodes RAM/IO windows, steers byte lanes and
// reports faults. Define CPU_BUS_TIMEOUT_EN to compile in the ACCESS watchdog.
module cpu_bus_ctrl
  import bus_pkg::*;
#(
  parameter logic [31:0] RAM_BASE       = 32'h40000000,
  parameter int unsigned RAM_SIZE_LOG2  = 16,
  parameter logic [31:0] IO_BASE        = 32'hF0000000,
  parameter int unsigned IO_SIZE_LOG2   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_data_out,
  input  logic [3:0]  ma_data_mask,
  input  logic        ma_rd_req,
  input  logic        ma_wr_req,
  output logic [31:0] ma_data_in,
  output logic        ma_done,
  output logic        ma_timeout,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        ram_sel,
  output logic        io_sel,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] io_rdata,
  input  logic        ram_ack,
  input  logic        io_ack
);

  logic [1:0]  r_state;
  logic        r_fault;
  logic [1:0]  r_win;
  logic        r_bus_rd;
  logic        r_bus_wr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic [31:0] r_data_in;

  logic        w_req;
  logic        w_ram_hit;
  logic        w_io_hit;
  logic        w_ack;
  logic        w_expired;
  logic [31:0] w_rdata_sel;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_rdata_sh;

  assign w_req     = ma_rd_req | ma_wr_req;
  assign w_ram_hit = (ma_addr[31:RAM_SIZE_LOG2] == RAM_BASE[31:RAM_SIZE_LOG2]);
  assign w_io_hit  = (ma_addr[31:IO_SIZE_LOG2] == IO_BASE[31:IO_SIZE_LOG2]);

  assign w_rdata_sel = (r_win == WIN_IO) ? io_rdata : ram_rdata;
  assign w_ack = (r_state == ST_ACCESS) &&
                 (((r_win == WIN_RAM) && ram_ack) || ((r_win == WIN_IO) && io_ack));

`ifdef CPU_BUS_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd;

  // Held at zero outside ACCESS, so it is already clear on entry.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_ACCESS)) begin
      r_wd <= '0;
    end else if (!w_ack) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  assign w_expired = (r_state == ST_ACCESS) && (r_wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_expired = 1'b0;
`endif

  // Bus-side lanes derive from latched request fields, so they hold for all of ACCESS.
  cpu_bus_lane_aligner u_aligner (
    .i_off   (r_addr[1:0]),
    .i_mask  (r_mask),
    .i_wdata (r_wdata),
    .i_rdata (w_rdata_sel),
    .o_be    (w_be),
    .o_wdata (w_wdata_sh),
    .o_rdata (w_rdata_sh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_fault   <= 1'b0;
      r_win     <= WIN_NONE;
      r_bus_rd  <= 1'b0;
      r_bus_wr  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mask    <= '0;
      r_data_in <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr  <= ma_addr;
            r_wdata <= ma_data_out;
            r_mask  <= ma_data_mask;
            if (w_ram_hit || w_io_hit) begin
              r_state  <= ST_ACCESS;
              r_fault  <= 1'b0;
              r_win    <= w_ram_hit ? WIN_RAM : WIN_IO;
              r_bus_rd <= ma_rd_req;
              r_bus_wr <= !ma_rd_req;
            end else begin
              r_state <= ST_RESPOND;
              r_fault <= 1'b1;
            end
          end
        end
        ST_ACCESS: begin
          if (w_ack || w_expired) begin
            if (w_ack && r_bus_rd) begin
              r_data_in <= w_rdata_sh;
            end
            r_state  <= ST_RESPOND;
            r_fault  <= !w_ack;
            r_win    <= WIN_NONE;
            r_bus_rd <= 1'b0;
            r_bus_wr <= 1'b0;
          end
        end
        ST_RESPOND: begin
          r_state <= ST_RECOVER;
        end
        default: begin
          r_state <= ST_IDLE;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign ma_data_in = r_data_in;
  assign ma_done    = (r_state == ST_RESPOND) && !r_fault;
  assign ma_timeout = (r_state == ST_RESPOND) && r_fault;
  assign bus_addr   = {r_addr[31:2], 2'b00};
  assign bus_wdata  = w_wdata_sh;
  assign bus_be     = w_be;
  assign bus_rd     = r_bus_rd;
  assign bus_wr     = r_bus_wr;
  assign ram_sel    = (r_win == WIN_RAM);
  assign io_sel     = (r_win == WIN_IO);

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: directed cases plus randomized
// transactions against an arithmetic reference model.
module tb_cpu_bus_ctrl;

  localparam int TO = 4;
  localparam longint unsigned RAM_LO = 64'h40000000;
  localparam longint unsigned IO_LO  = 64'hF0000000;
  localparam longint unsigned WIN_SZ = 64'h10000;
`ifdef CPU_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ma_addr, ma_data_out, ma_data_in;
  logic [3:0]  ma_data_mask;
  logic        ma_rd_req, ma_wr_req, ma_done, ma_timeout;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rd, bus_wr, ram_sel, io_sel;
  logic [31:0] ram_rdata, io_rdata;
  logic        ram_ack, io_ack;

  always #5 clk = ~clk;

  cpu_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ma_addr(ma_addr), .ma_data_out(ma_data_out), .ma_data_mask(ma_data_mask),
    .ma_rd_req(ma_rd_req), .ma_wr_req(ma_wr_req),
    .ma_data_in(ma_data_in), .ma_done(ma_done), .ma_timeout(ma_timeout),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .ram_sel(ram_sel), .io_sel(io_sel),
    .ram_rdata(ram_rdata), .io_rdata(io_rdata), .ram_ack(ram_ack), .io_ack(io_ack)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_data_in = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // 0 = unmapped, 1 = RAM, 2 = IO; RAM wins on overlap.
  function automatic int decode(input logic [31:0] a);
    longint unsigned x = 64'(a);
    if (x >= RAM_LO && x < RAM_LO + WIN_SZ) return 1;
    if (x >= IO_LO && x < IO_LO + WIN_SZ) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] m_be(input logic [3:0] mask, input int off);
    longint unsigned v = 64'(mask) * (64'd1 << off);
    return 32'(v % 16);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input int off);
    longint unsigned v = 64'(d) * (64'd1 << (8 * off));
    return 32'(v % (64'd1 << 32));
  endfunction

  function automatic logic [31:0] m_rdata(input logic [31:0] d, input int off);
    return 32'(64'(d) / (64'd1 << (8 * off)));
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ".done"}, 32'(ma_done), 0);
    chk({tag, ".timeout"}, 32'(ma_timeout), 0);
    chk({tag, ".ram_sel"}, 32'(ram_sel), 0);
    chk({tag, ".io_sel"}, 32'(io_sel), 0);
    chk({tag, ".bus_rd"}, 32'(bus_rd), 0);
    chk({tag, ".bus_wr"}, 32'(bus_wr), 0);
  endtask

  // ack_cyc: cycle (1-based from ACCESS start) in which the selected slave acks; 0 = never.
  task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] mask, input bit rd, input bit both,
                     input int ack_cyc, input logic [31:0] rdv);
    int  win = decode(addr);
    int  off = int'(addr % 4);
    bit  fault;
    int  resp;
    if (win == 0) begin
      fault = 1'b1; resp = 1;
    end else if (ack_cyc >= 1 && (!TO_EN || ack_cyc <= TO)) begin
      fault = 1'b0; resp = ack_cyc + 1;
    end else begin
      fault = 1'b1; resp = TO + 1;
    end
    @(posedge clk); #1;
    ma_addr = addr; ma_data_out = data; ma_data_mask = mask;
    ma_rd_req = rd; ma_wr_req = !rd || both;
    for (int c = 1; c <= resp + 2; c++) begin
      @(posedge clk); #1;
      if (c == resp + 2) begin
        ma_rd_req = 1'b0; ma_wr_req = 1'b0;
      end
      ram_ack   = (win == 1 && c < resp) ? (c == ack_cyc) : 1'($urandom);
      io_ack    = (win == 2 && c < resp) ? (c == ack_cyc) : 1'($urandom);
      ram_rdata = (win == 1 && c == ack_cyc) ? rdv : $urandom;
      io_rdata  = (win == 2 && c == ack_cyc) ? rdv : $urandom;
      @(negedge clk);
      if (c < resp) begin
        chk({tag, ".acc.ram_sel"}, 32'(ram_sel), 32'(win == 1));
        chk({tag, ".acc.io_sel"}, 32'(io_sel), 32'(win == 2));
        chk({tag, ".acc.bus_rd"}, 32'(bus_rd), 32'(rd));
        chk({tag, ".acc.bus_wr"}, 32'(bus_wr), 32'(!rd));
        chk({tag, ".acc.bus_addr"}, bus_addr, addr - 32'(off));
        chk({tag, ".acc.bus_be"}, 32'(bus_be), m_be(mask, off));
        chk({tag, ".acc.bus_wdata"}, bus_wdata, m_wdata(data, off));
        chk({tag, ".acc.done"}, 32'(ma_done), 0);
        chk({tag, ".acc.timeout"}, 32'(ma_timeout), 0);
      end else if (c == resp) begin
        if (!fault && rd) m_data_in = m_rdata(rdv, off);
        chk({tag, ".rsp.done"}, 32'(ma_done), 32'(!fault));
        chk({tag, ".rsp.timeout"}, 32'(ma_timeout), 32'(fault));
        chk({tag, ".rsp.sel"}, 32'({ram_sel, io_sel, bus_rd, bus_wr}), 0);
        chk({tag, ".rsp.data_in"}, ma_data_in, m_data_in);
      end else begin
        chk_quiet({tag, ".post"});
        chk({tag, ".post.data_in"}, ma_data_in, m_data_in);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ma_addr = '0; ma_data_out = '0; ma_data_mask = '0;
    ma_rd_req = 1'b0; ma_wr_req = 1'b0;
    ram_rdata = '0; io_rdata = '0; ram_ack = 1'b0; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    chk("reset.data_in", ma_data_in, 0);
    chk("reset.bus_be", 32'(bus_be), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    txn("ram_word_wr", 32'h40000010, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0, 1, '0);
    txn("ram_byte_rd", 32'h40000003, 32'h0, 4'b0001, 1'b1, 1'b0, 4, 32'hA5000000);
    chk("ram_byte_rd.value", ma_data_in, 32'h000000A5);
    txn("io_half_wr", 32'hF0000002, 32'h00001234, 4'b0011, 1'b0, 1'b0, 2, '0);
    txn("unmapped_rd", 32'h00001000, 32'h0, 4'b1111, 1'b1, 1'b0, 1, 32'h12345678);
    txn("both_req_rd", 32'hF0000101, 32'h0, 4'b0011, 1'b1, 1'b1, 3, 32'h00BEEF00);
    chk("both_req_rd.value", ma_data_in, 32'h0000BEEF);
    if (TO_EN) begin
      txn("wd_expire", 32'h40000020, 32'h0, 4'b1111, 1'b1, 1'b0, 0, 32'h11111111);
      txn("wd_ack_last", 32'h40000020, 32'h0, 4'b1111, 1'b1, 1'b0, TO, 32'h22222222);
    end

    // Reset in the second ACCESS cycle with an ack pending.
    @(posedge clk); #1;
    ma_addr = 32'h40000024; ma_data_mask = 4'b1111; ma_rd_req = 1'b1; ma_wr_req = 1'b0;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid.ram_sel", 32'(ram_sel), 1);
    @(posedge clk); #1;
    rst = 1'b1; ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0; ma_rd_req = 1'b0;
    m_data_in = '0;
    @(negedge clk);
    chk_quiet("rst_mid.after");
    chk("rst_mid.data_in", ma_data_in, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      ram_ack = 1'b0;
      @(negedge clk);
      chk_quiet("rst_mid.late_ack");
      chk("rst_mid.late.data_in", ma_data_in, 0);
    end

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [3:0]  mk;
      int          sel = int'($urandom_range(0, 4));
      int          ak;
      case (sel)
        0, 1:    a = 32'h40000000 + 32'($urandom_range(0, 32'hFFFF));
        2, 3:    a = 32'hF0000000 + 32'($urandom_range(0, 32'hFFFF));
        default: a = 32'h80000000 ^ $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       mk = 4'b0001;
        1:       mk = 4'b0011;
        default: mk = 4'b1111;
      endcase
      ak = TO_EN ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 6));
      txn("rand", a, $urandom, mk, 1'($urandom), 1'($urandom), ak, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
